// File: rtl/data_mem_arbiter_if.sv
// Bundle of the two requester ports and the memory-manager port of the arbiter.
`timescale 1ns/1ps
interface data_mem_arbiter_if;
    logic        r0_req_i;
    logic [31:0] r0_addr_i;
    logic [31:0] r0_data_i;
    logic        r0_we_i;
    logic        r0_byte_i;
    logic        r0_ack_o;
    logic [31:0] r0_data_o;

    logic        r1_req_i;
    logic [31:0] r1_addr_i;
    logic [31:0] r1_data_i;
    logic        r1_we_i;
    logic        r1_byte_i;
    logic        r1_ack_o;
    logic [31:0] r1_data_o;

    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_wren_o;
    logic [31:0] mem_q_i;
    logic        busy_o;

    modport slave (
        input  r0_req_i, r0_addr_i, r0_data_i, r0_we_i, r0_byte_i,
        output r0_ack_o, r0_data_o,
        input  r1_req_i, r1_addr_i, r1_data_i, r1_we_i, r1_byte_i,
        output r1_ack_o, r1_data_o,
        output mem_addr_o, mem_data_o, mem_wren_o, busy_o,
        input  mem_q_i
    );

    modport master (
        output r0_req_i, r0_addr_i, r0_data_i, r0_we_i, r0_byte_i,
        input  r0_ack_o, r0_data_o,
        output r1_req_i, r1_addr_i, r1_data_i, r1_we_i, r1_byte_i,
        input  r1_ack_o, r1_data_o,
        input  mem_addr_o, mem_data_o, mem_wren_o, busy_o,
        output mem_q_i
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin two-requester arbiter serialising word/byte accesses to a synchronous
// data memory; byte stores are done as read-modify-write of the containing word.
`timescale 1ns/1ps
module data_mem_arbiter #(
    parameter int RD_LAT = 2
) (
    input  logic             CLK,
    input  logic             RST,
    data_mem_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, READ, WRITE, MERGE_WR, ACK} state_t;

    localparam logic [2:0] LAST_CNT = 3'(RD_LAT - 1);

    state_t      state, state_nxt;
    logic        gnt, last_grant, sel, any_req, sel_wr;
    logic [31:0] addr_q, data_q, word_q, merged, ack_data;
    logic [31:0] r0_rdata, r1_rdata;
    logic        we_q, byte_q;
    logic [2:0]  cnt;
    logic [7:0]  lane_byte;

    // On a tie the requester that was not served last wins.
    assign any_req = bus.r0_req_i | bus.r1_req_i;
    assign sel     = (bus.r0_req_i & bus.r1_req_i) ? ~last_grant : bus.r1_req_i;
    assign sel_wr  = sel ? (bus.r1_we_i & ~bus.r1_byte_i) : (bus.r0_we_i & ~bus.r0_byte_i);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (any_req) state_nxt = sel_wr ? WRITE : READ;
            READ:     if (cnt == LAST_CNT) state_nxt = (we_q & byte_q) ? MERGE_WR : ACK;
            WRITE:    state_nxt = ACK;
            MERGE_WR: state_nxt = ACK;
            ACK:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            gnt        <= 1'b0;
            last_grant <= 1'b1;
            addr_q     <= '0;
            data_q     <= '0;
            we_q       <= 1'b0;
            byte_q     <= 1'b0;
            cnt        <= '0;
            word_q     <= '0;
            r0_rdata   <= '0;
            r1_rdata   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (any_req) begin
                    gnt    <= sel;
                    addr_q <= sel ? bus.r1_addr_i : bus.r0_addr_i;
                    data_q <= sel ? bus.r1_data_i : bus.r0_data_i;
                    we_q   <= sel ? bus.r1_we_i   : bus.r0_we_i;
                    byte_q <= sel ? bus.r1_byte_i : bus.r0_byte_i;
                end
                READ: if (cnt == LAST_CNT) begin
                    cnt    <= '0;
                    word_q <= bus.mem_q_i;
                end else begin
                    cnt <= cnt + 3'd1;
                end
                ACK: begin
                    last_grant <= gnt;
                    if (gnt) r1_rdata <= ack_data;
                    else     r0_rdata <= ack_data;
                end
                default: ;
            endcase
        end
    end

    // Byte-lane insert for the write half of a byte store.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign merged[8*i +: 8] = (addr_q[1:0] == 2'(i)) ? data_q[7:0] : word_q[8*i +: 8];
    end

    assign lane_byte = word_q[{addr_q[1:0], 3'b000} +: 8];
    assign ack_data  = we_q ? 32'd0 : (byte_q ? {24'd0, lane_byte} : word_q);

    assign bus.busy_o     = (state != IDLE);
    assign bus.mem_addr_o = (state != IDLE) ? addr_q : 32'd0;
    assign bus.mem_wren_o = (state == WRITE) || (state == MERGE_WR);
    assign bus.mem_data_o = (state == WRITE)    ? data_q :
                            (state == MERGE_WR) ? merged : 32'd0;

    assign bus.r0_ack_o  = (state == ACK) & ~gnt;
    assign bus.r1_ack_o  = (state == ACK) &  gnt;
    assign bus.r0_data_o = bus.r0_ack_o ? ack_data : r0_rdata;
    assign bus.r1_data_o = bus.r1_ack_o ? ack_data : r1_rdata;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomised scoreboard bench for data_mem_arbiter with a latency-aware memory model.
`timescale 1ns/1ps
module tb_data_mem_arbiter;
    parameter int RD_LAT = 2;

    typedef struct packed {
        logic        we;
        logic        bt;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    typedef struct {
        logic [31:0] data;
        int          cyc;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_m = 1;

    logic [31:0] ram [64];
    logic [31:0] mdl [64];
    logic [31:0] stab_addr = '0;
    logic        stab_busy = 1'b0;
    int          stab = 0;

    resp_t rq0[$];
    resp_t rq1[$];
    wr_t   wq[$];
    int    oq[$];

    data_mem_arbiter_if bus();
    data_mem_arbiter #(.RD_LAT(RD_LAT)) dut (.CLK(clk), .RST(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        if (i == 8)  return 32'h11223344;
        if (i == 20) return 32'h01020304;
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0F0F;
    endfunction

    // Memory returns valid data only once the address has been held RD_LAT cycles.
    always @(posedge clk) begin
        if (load) for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
        else if (bus.mem_wren_o) ram[bus.mem_addr_o[7:2]] <= bus.mem_data_o;
        stab_addr <= bus.mem_addr_o;
        stab_busy <= bus.busy_o;
        stab <= bus.busy_o ? ((stab_busy && bus.mem_addr_o == stab_addr) ? stab + 1 : 1) : 0;
    end
    assign bus.mem_q_i = (RD_LAT == 1 || (bus.mem_addr_o == stab_addr && stab >= RD_LAT - 1))
                         ? ram[bus.mem_addr_o[7:2]] : 32'hA5A55A5A;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic txn_t mk(input logic we, input logic bt, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.we = we; t.bt = bt; t.addr = a; t.data = d;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.we   = 1'($urandom_range(0, 1));
        t.bt   = 1'($urandom_range(0, 1));
        t.addr = 32'($urandom_range(0, 63));
        if (!t.bt) t.addr[1:0] = 2'b00;
        t.data = $urandom;
        return t;
    endfunction

    // Reference: apply one access to the word array, record what the DUT must show.
    function automatic int model(input int who, input txn_t t, input int g);
        int          i, sh, lat;
        logic [31:0] w, rsp;
        wr_t         wr;
        resp_t       r;
        i   = int'(t.addr[7:2]);
        sh  = 8 * int'(t.addr[1:0]);
        w   = mdl[i];
        rsp = 32'd0;
        if (t.we && !t.bt) begin
            mdl[i] = t.data;
            wr.addr = t.addr; wr.data = t.data; wq.push_back(wr);
            lat = 2;
        end else if (t.we) begin
            w = (w & ~(32'hFF << sh)) | ({24'd0, t.data[7:0]} << sh);
            mdl[i] = w;
            wr.addr = t.addr; wr.data = w; wq.push_back(wr);
            lat = RD_LAT + 2;
        end else begin
            rsp = t.bt ? ((w >> sh) & 32'hFF) : w;
            lat = RD_LAT + 1;
        end
        r.data = rsp; r.cyc = g + lat;
        if (who == 0) rq0.push_back(r); else rq1.push_back(r);
        oq.push_back(who);
        last_m = who;
        return lat;
    endfunction

    task automatic set(input int who, input logic req, input txn_t t);
        if (who == 0) begin
            bus.r0_req_i = req; bus.r0_addr_i = t.addr; bus.r0_data_i = t.data;
            bus.r0_we_i = t.we; bus.r0_byte_i = t.bt;
        end else begin
            bus.r1_req_i = req; bus.r1_addr_i = t.addr; bus.r1_data_i = t.data;
            bus.r1_we_i = t.we; bus.r1_byte_i = t.bt;
        end
    endtask

    // Hold req until ack; after the grant cycle the other inputs are scrambled.
    task automatic drive(input int who, input txn_t t, input int g);
        logic done, scr;
        int   n;
        set(who, 1'b1, t);
        done = 1'b0; scr = 1'b0; n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            if (who == 0 ? bus.r0_ack_o : bus.r1_ack_o) done = 1'b1;
            else if (!scr && cyc > g) begin
                scr = 1'b1;
                set(who, 1'b1, rand_txn());
            end
        end
        chk(who == 0 ? "r0_ack_timeout" : "r1_ack_timeout", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
        set(who, 1'b0, t);
    endtask

    task automatic run_round(input logic u0, input logic u1, input txn_t t0, input txn_t t1);
        int c, first, ack_a, g0, g1;
        g0 = 0; g1 = 0;
        @(posedge clk); #1;
        c = cyc;
        if (u0 && u1) first = (last_m == 1) ? 0 : 1;
        else          first = u0 ? 0 : 1;
        ack_a = c + model(first, (first == 0) ? t0 : t1, c);
        if (first == 0) g0 = c; else g1 = c;
        if (u0 && u1) begin
            if (first == 0) begin g1 = ack_a + 1; void'(model(1, t1, g1)); end
            else            begin g0 = ack_a + 1; void'(model(0, t0, g0)); end
        end
        fork
            if (u0) drive(0, t0, g0);
            if (u1) drive(1, t1, g1);
        join
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes memory or acks.
    initial begin
        logic [31:0] hold0, hold1;
        logic        pw;
        resp_t       r;
        wr_t         w;
        hold0 = '0; hold1 = '0; pw = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold0 = '0; hold1 = '0; pw = 1'b0;
            end else begin
                chk("dual_ack", {31'd0, bus.r0_ack_o & bus.r1_ack_o}, 32'd0);
                chk("wren_run", {31'd0, bus.mem_wren_o & pw}, 32'd0);
                pw = bus.mem_wren_o;
                if (bus.mem_wren_o) begin
                    if (wq.size() == 0) chk("unexpected_wren", {31'd0, bus.mem_wren_o}, 32'd0);
                    else begin
                        w = wq.pop_front();
                        chk("wr_addr", bus.mem_addr_o, w.addr);
                        chk("wr_data", bus.mem_data_o, w.data);
                    end
                end
                if (bus.r0_ack_o) begin
                    if (rq0.size() == 0 || oq.size() == 0)
                        chk("unexpected_r0_ack", {31'd0, bus.r0_ack_o}, 32'd0);
                    else begin
                        r = rq0.pop_front();
                        chk("grant_order_r0", 32'd0, 32'(oq.pop_front()));
                        chk("r0_data", bus.r0_data_o, r.data);
                        chk("r0_ack_cycle", 32'(cyc), 32'(r.cyc));
                        hold0 = r.data;
                    end
                end else chk("r0_hold", bus.r0_data_o, hold0);
                if (bus.r1_ack_o) begin
                    if (rq1.size() == 0 || oq.size() == 0)
                        chk("unexpected_r1_ack", {31'd0, bus.r1_ack_o}, 32'd0);
                    else begin
                        r = rq1.pop_front();
                        chk("grant_order_r1", 32'd1, 32'(oq.pop_front()));
                        chk("r1_data", bus.r1_data_o, r.data);
                        chk("r1_ack_cycle", 32'(cyc), 32'(r.cyc));
                        hold1 = r.data;
                    end
                end else chk("r1_hold", bus.r1_data_o, hold1);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t z;
        z = mk(1'b0, 1'b0, 32'd0, 32'd0);
        set(0, 1'b0, z);
        set(1, 1'b0, z);
        for (int i = 0; i < 64; i++) mdl[i] = init_word(i);
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("rst_wren", {31'd0, bus.mem_wren_o}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
        chk("rst_mem_data", bus.mem_data_o, 32'd0);
        chk("rst_acks", {30'd0, bus.r1_ack_o, bus.r0_ack_o}, 32'd0);
        chk("rst_r0_data", bus.r0_data_o, 32'd0);
        chk("rst_r1_data", bus.r1_data_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Contention straight out of reset, then the directed scenarios.
        run_round(1'b1, 1'b1, mk(1'b0, 1'b0, 32'h04, 32'd0), mk(1'b0, 1'b0, 32'h08, 32'd0));
        run_round(1'b1, 1'b0, mk(1'b1, 1'b0, 32'h10, 32'hDEADBEEF), z);
        run_round(1'b1, 1'b0, mk(1'b0, 1'b0, 32'h10, 32'd0), z);
        run_round(1'b0, 1'b1, z, mk(1'b1, 1'b1, 32'h22, 32'h000000AA));
        run_round(1'b0, 1'b1, z, mk(1'b0, 1'b1, 32'h23, 32'd0));
        for (int k = 0; k < 4; k++)
            run_round(1'b1, 1'b1, mk(1'b0, 1'b0, 32'h20, 32'd0), mk(1'b0, 1'b1, 32'h21, 32'd0));
        run_round(1'b1, 1'b0, mk(1'b0, 1'b0, 32'h30, 32'd0), z);

        for (int k = 0; k < 300; k++) begin
            int m;
            m = $urandom_range(0, 2);
            run_round(m != 1, m != 0, rand_txn(), rand_txn());
        end

        // Abort a byte store during its read phase.
        @(posedge clk); #1;
        set(0, 1'b1, mk(1'b1, 1'b1, 32'h50, 32'h000000EE));
        @(posedge clk); #1;
        chk("rmw_in_read", {31'd0, bus.busy_o}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("abort_wren", {31'd0, bus.mem_wren_o}, 32'd0);
        chk("abort_acks", {30'd0, bus.r1_ack_o, bus.r0_ack_o}, 32'd0);
        set(0, 1'b0, z);
        @(posedge clk); #1;
        rst = 1'b0;
        last_m = 1;
        repeat (3) @(posedge clk);
        run_round(1'b1, 1'b0, mk(1'b0, 1'b0, 32'h50, 32'd0), z);
        run_round(1'b1, 1'b1, mk(1'b0, 1'b1, 32'h52, 32'd0), mk(1'b0, 1'b0, 32'h50, 32'd0));

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", 32'(rq0.size() + rq1.size() + wq.size() + oq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
